// File: rtl/sha256_msg_mem.sv
// sha256_msg_mem: double-buffered message-block store feeding the sha256 read port
module sha256_msg_mem #(
  parameter int WORDS = 16,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic        clk_axi,
  input  logic        rst,
  input  logic        wr_vld,
  output logic        wr_rdy,
  input  logic [31:0] wr_data,
  output logic        blk_rdy,
  input  logic        blk_done,
  input  logic        mem_addr_vld,
  input  logic [31:0] mem_addr,
  output logic        mem_data_vld,
  output logic [31:0] mem_data,
  output logic [31:0] blk_cnt,
  output logic        err
);
  logic [31:0] mem [2*WORDS];
  logic [1:0] full, full_n;
  logic wr_bank, rd_bank, wr_fire, wr_last, rel;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic unused_addr;
  assign wr_rdy = !full[wr_bank];
  assign blk_rdy = full[rd_bank];
  assign wr_fire = wr_vld && wr_rdy;
  assign wr_last = wr_fire && wr_idx == IDX_W'(WORDS - 1);
  assign rel = blk_done && blk_rdy;
  assign rd_idx = mem_addr[IDX_W+1:2];
  assign unused_addr = ^{mem_addr[31:IDX_W+2], mem_addr[1:0]};
  // a completing write and a release always hit different banks
  always_comb begin
    full_n = full;
    if (wr_last) full_n[wr_bank] = 1'b1;
    if (rel) full_n[rd_bank] = 1'b0;
  end
  always_ff @(posedge clk_axi)
    if (wr_fire) mem[{wr_bank, wr_idx}] <= wr_data;
  always_ff @(posedge clk_axi) begin
    if (rst) begin
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx <= '0;
      mem_data_vld <= 1'b0;
      mem_data <= '0;
      blk_cnt <= '0;
      err <= 1'b0;
    end else begin
      full <= full_n;
      if (wr_fire) wr_idx <= wr_idx + 1'b1;
      if (wr_last) wr_bank <= !wr_bank;
      if (rel) begin
        rd_bank <= !rd_bank;
        blk_cnt <= blk_cnt + 32'd1;
      end
      mem_data_vld <= mem_addr_vld;
      if (mem_addr_vld) mem_data <= mem[{rd_bank, rd_idx}];
      if ((blk_done || mem_addr_vld) && !blk_rdy) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sha256_msg_mem.sv
// tb_sha256_msg_mem: directed table, corner sequences and random traffic against a block-count model
module tb_sha256_msg_mem;
  localparam int W = 16;
  logic clk_axi = 1'b0, rst = 1'b0, wr_vld = 1'b0, blk_done = 1'b0, mem_addr_vld = 1'b0;
  logic [31:0] wr_data = '0, mem_addr = '0;
  logic wr_rdy, blk_rdy, mem_data_vld, err;
  logic [31:0] mem_data, blk_cnt;
  int n_cmp = 0, n_bad = 0;
  int m_comp, m_rel, m_idx;
  logic [31:0] m_bank [2][W];
  bit m_known [2][W];
  bit m_vld, m_dk, m_err;
  logic [31:0] m_data;
  typedef struct { logic [31:0] addr; logic [31:0] exp; } vec_t;
  vec_t tbl [6];
  sha256_msg_mem #(.WORDS(W)) dut (
    .clk_axi(clk_axi), .rst(rst), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
    .blk_rdy(blk_rdy), .blk_done(blk_done), .mem_addr_vld(mem_addr_vld), .mem_addr(mem_addr),
    .mem_data_vld(mem_data_vld), .mem_data(mem_data), .blk_cnt(blk_cnt), .err(err)
  );
  always #5 clk_axi = !clk_axi;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    int wb = m_comp % 2;
    int rb = m_rel % 2;
    bit wrdy = (m_comp - m_rel) < 2;
    bit brdy = m_comp > m_rel;
    int ri = int'((mem_addr >> 2) % W);
    if (mem_addr_vld) begin
      m_data = m_bank[rb][ri];
      m_dk = m_known[rb][ri];
      if (!brdy) m_err = 1;
    end
    m_vld = mem_addr_vld;
    if (blk_done && !brdy) m_err = 1;
    if (wr_vld && wrdy) begin
      m_bank[wb][m_idx] = wr_data;
      m_known[wb][m_idx] = 1;
      if (m_idx == W - 1) begin
        m_idx = 0;
        m_comp++;
      end else m_idx++;
    end
    if (blk_done && brdy) m_rel++;
    if (rst) begin
      m_comp = 0; m_rel = 0; m_idx = 0;
      m_vld = 0; m_data = '0; m_dk = 1; m_err = 0;
    end
    @(posedge clk_axi);
    #1;
    cmp("wr_rdy", {31'd0, wr_rdy}, {31'd0, (m_comp - m_rel) < 2});
    cmp("blk_rdy", {31'd0, blk_rdy}, {31'd0, m_comp > m_rel});
    cmp("mem_data_vld", {31'd0, mem_data_vld}, {31'd0, m_vld});
    if (m_dk) cmp("mem_data", mem_data, m_data);
    cmp("blk_cnt", blk_cnt, 32'(m_rel));
    cmp("err", {31'd0, err}, {31'd0, m_err});
  endtask
  task automatic clr();
    rst = 0; wr_vld = 0; blk_done = 0; mem_addr_vld = 0;
  endtask
  task automatic do_rst();
    clr(); rst = 1; step(); rst = 0;
  endtask
  task automatic wr(input logic [31:0] d);
    wr_vld = 1; wr_data = d; step(); wr_vld = 0;
  endtask
  task automatic rd(input logic [31:0] a);
    mem_addr_vld = 1; mem_addr = a; step(); mem_addr_vld = 0;
  endtask
  initial begin
    m_comp = 0; m_rel = 0; m_idx = 0; m_vld = 0; m_dk = 0; m_err = 0; m_data = '0;
    foreach (m_known[b, i]) m_known[b][i] = 0;
    tbl[0] = '{32'h0000_0000, 32'h1000_0000};
    tbl[1] = '{32'h0000_0044, 32'h1000_0001};
    tbl[2] = '{32'hFFFF_FFC4, 32'h1000_0001};
    tbl[3] = '{32'h0000_0007, 32'h1000_0001};
    tbl[4] = '{32'h0000_003C, 32'h1000_000F};
    tbl[5] = '{32'h0000_0008, 32'h1000_0002};
    do_rst();
    cmp("rst_wr_rdy", {31'd0, wr_rdy}, 32'd1);
    cmp("rst_mem_data", mem_data, 32'd0);
    for (int i = 0; i < W; i++) wr(32'(i));
    cmp("fill_blk_rdy", {31'd0, blk_rdy}, 32'd1);
    cmp("fill_wr_rdy", {31'd0, wr_rdy}, 32'd1);
    for (int i = 0; i < W; i++) begin
      rd(32'(4 * i));
      cmp("seq_rd", mem_data, 32'(i));
      cmp("seq_vld", {31'd0, mem_data_vld}, 32'd1);
    end
    do_rst();
    for (int i = 0; i < W; i++) wr(32'h1000_0000 + 32'(i));
    for (int i = 0; i < W; i++) wr(32'h2000_0000 + 32'(i));
    cmp("both_full_wr_rdy", {31'd0, wr_rdy}, 32'd0);
    wr(32'hDEAD_BEEF);
    cmp("blocked_wr_rdy", {31'd0, wr_rdy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      rd(tbl[i].addr);
      cmp($sformatf("tbl_rd%0d", i), mem_data, tbl[i].exp);
    end
    blk_done = 1; step(); blk_done = 0;
    cmp("rel_cnt", blk_cnt, 32'd1);
    cmp("rel_wr_rdy", {31'd0, wr_rdy}, 32'd1);
    rd(32'h0C);
    cmp("bank1_rd", mem_data, 32'h2000_0003);
    do_rst();
    rd(32'h0);
    cmp("err_rd", {31'd0, err}, 32'd1);
    cmp("err_rd_vld", {31'd0, mem_data_vld}, 32'd1);
    blk_done = 1; step(); blk_done = 0;
    cmp("err_done_cnt", blk_cnt, 32'd0);
    step();
    cmp("err_sticky", {31'd0, err}, 32'd1);
    do_rst();
    for (int i = 0; i < W; i++) wr(32'h3000_0000 + 32'(i));
    for (int i = 0; i < W - 1; i++) wr(32'h4000_0000 + 32'(i));
    wr_vld = 1; wr_data = 32'h4000_000F; blk_done = 1; mem_addr_vld = 1; mem_addr = 32'h08;
    step(); clr();
    cmp("same_rd", mem_data, 32'h3000_0002);
    cmp("same_blk_rdy", {31'd0, blk_rdy}, 32'd1);
    cmp("same_cnt", blk_cnt, 32'd1);
    rd(32'h3C);
    cmp("same_bank1", mem_data, 32'h4000_000F);
    do_rst();
    for (int i = 0; i < 7; i++) wr(32'h5000_0000 + 32'(i));
    rst = 1; mem_addr_vld = 1; mem_addr = 32'h0; step(); clr();
    cmp("mid_rst_vld", {31'd0, mem_data_vld}, 32'd0);
    cmp("mid_rst_blk_rdy", {31'd0, blk_rdy}, 32'd0);
    for (int i = 0; i < W; i++) wr(32'h6000_0000 + 32'(i));
    cmp("refill_blk_rdy", {31'd0, blk_rdy}, 32'd1);
    rd(32'h14);
    cmp("refill_rd", mem_data, 32'h6000_0005);
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 300) == 0;
      wr_vld = ($urandom % 10) < 7;
      wr_data = $urandom;
      blk_done = ($urandom % 8) == 0;
      mem_addr_vld = ($urandom % 2) == 1;
      mem_addr = $urandom;
      step();
    end
    clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
